// File: rtl/fifo_wr_arb_pkg.sv
// rtl/fifo_wr_arb_pkg.sv - shared types, constants and width helper for fifo_wr_arbiter
package fifo_wr_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   localparam int STALL_CNT_W = 16;

   // Width of a counter or index able to hold values 0..n-1 (never below 1 bit)
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin picker: first set request at or after the pointer
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IW      = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_ptr,
   output logic               o_found,
   output logic [IW-1:0]      o_idx
);

   int j;

   // Scan offsets from farthest to nearest so the nearest hit to the pointer wins
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      j       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = (int'(i_ptr) + k) % NUM_REQ;
         if (i_req[j]) begin
            o_found = 1'b1;
            o_idx   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the FIFO write port (optional FIFO_WR_ARB_STALL_CNT_EN stall counter)
module fifo_wr_arbiter
   import fifo_wr_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4
) (
   input  logic                          i_wr_clk,
   input  logic                          i_rst,
   input  logic [NUM_REQ-1:0]            i_req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
   input  logic                          i_full_flag,
   output logic [NUM_REQ-1:0]            o_gnt,
   output logic [NUM_REQ-1:0]            o_ack,
   output logic                          o_wr_en,
   output logic [DATA_WIDTH-1:0]         o_wr_data,
   output logic                          o_busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0]        o_stall_cnt
`endif
);

   localparam int IW = idx_width(NUM_REQ);
   localparam int CW = idx_width(BURST_LEN + 1);

   state_e               state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [IW-1:0]        owner_q, owner_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   logic                 accept;
   logic                 rel;
   logic [IW-1:0]        nxt_ptr;
   logic [IW-1:0]        pick_ptr;
   logic                 pick_found;
   logic [IW-1:0]        pick_idx;

   assign accept  = (state_q == GRANT) & i_req[owner_q] & ~i_full_flag;
   assign rel     = (state_q == GRANT) &
                    (~i_req[owner_q] | (accept & (cnt_q == CW'(BURST_LEN - 1))));
   assign nxt_ptr = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + IW'(1);

   // On release the search starts just past the releasing owner; a withdrawn
   // owner is already absent from i_req, so it cannot be re-picked.
   assign pick_ptr = (state_q == GRANT) ? nxt_ptr : ptr_q;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr_pick (
      .i_req   (i_req),
      .i_ptr   (pick_ptr),
      .o_found (pick_found),
      .o_idx   (pick_idx)
   );

   // Next-state: grant from IDLE, release with same-cycle re-arbitration, burst counting
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (|i_req) begin
               state_d = GRANT;
               owner_d = pick_idx;
               gnt_d   = NUM_REQ'(1) << pick_idx;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (rel) begin
               ptr_d = nxt_ptr;
               cnt_d = '0;
               if (pick_found) begin
                  owner_d = pick_idx;
                  gnt_d   = NUM_REQ'(1) << pick_idx;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
               end
            end else if (accept) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // State register with synchronous reset
   always_ff @(posedge i_wr_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_gnt     = gnt_q;
   assign o_busy    = (state_q == GRANT);
   assign o_wr_en   = accept;
   assign o_ack     = accept ? (NUM_REQ'(1) << owner_q) : '0;
   assign o_wr_data = accept ? i_data[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;

`ifdef FIFO_WR_ARB_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_q;

   // Count cycles the owner wants to write but the FIFO is full, saturating
   always_ff @(posedge i_wr_clk) begin
      if (i_rst) begin
         stall_q <= '0;
      end else if ((state_q == GRANT) & i_req[owner_q] & i_full_flag & ~(&stall_q)) begin
         stall_q <= stall_q + STALL_CNT_W'(1);
      end
   end

   assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter with directed scenarios and a randomized reference-model run
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int BL = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [N*DW-1:0] data;
   logic          full;
   logic [N-1:0]  gnt, ack;
   logic          wr_en, busy;
   logic [DW-1:0] wr_data;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
   logic [15:0]   stall_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   // reference model: owner index (-1 = no grant), pointer, words in burst, stalls
   int m_owner = -1;
   int m_ptr   = 0;
   int m_cnt   = 0;
   int m_stall = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW),
      .BURST_LEN  (BL)
   ) dut (
      .i_wr_clk    (clk),
      .i_rst       (rst),
      .i_req       (req),
      .i_data      (data),
      .i_full_flag (full),
      .o_gnt       (gnt),
      .o_ack       (ack),
      .o_wr_en     (wr_en),
      .o_wr_data   (wr_data),
      .o_busy      (busy)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
      ,
      .o_stall_cnt (stall_cnt)
`endif
   );

   function automatic int first_from(input logic [N-1:0] r, input int start);
      for (int k = 0; k < N; k++) begin
         if (r[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   function automatic logic m_accept();
      return (m_owner >= 0) && req[m_owner] && !full;
   endfunction

   // advance the model by one clock using the inputs present at the edge
   task automatic model_step();
      logic acc;
      acc = m_accept();
      if (rst) begin
         m_owner = -1; m_ptr = 0; m_cnt = 0; m_stall = 0;
      end else begin
         if (m_owner >= 0 && req[m_owner] && full && m_stall < 65535) m_stall++;
         if (m_owner < 0) begin
            if (req != 0) begin
               m_owner = first_from(req, m_ptr);
               m_cnt   = 0;
            end
         end else if (!req[m_owner] || (acc && m_cnt + 1 == BL)) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = first_from(req, m_ptr);
            m_cnt   = 0;
         end else if (acc) begin
            m_cnt++;
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; full = 1'b0;
      cyc();
      rst = 1'b0;
      #1;
   endtask

   task automatic set_slice(input int k, input logic [DW-1:0] v);
      data[k*DW +: DW] = v;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b1111; full = 1'b0;
      for (int k = 0; k < N; k++) set_slice(k, 8'h30 + 8'(k));
      cyc(); cyc();
      #1;
      n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
      n_chk++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
      n_chk++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_chk++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", ack); end
`ifdef FIFO_WR_ARB_STALL_CNT_EN
      n_chk++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall: got %h expected 0000", stall_cnt); end
`endif
      rst = 1'b0;
      cyc();
      n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt); end
      n_chk++; if (wr_data !== 8'h30) begin n_fail++; $display("FAIL reset_first_data: got %h expected 30", wr_data); end
      req = '0;
      cyc(); cyc();
   endtask

   task automatic test_lone();
      do_reset();
      set_slice(2, 8'hA5);
      req = 4'b0100;
      #1;
      n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL lone_pre_gnt: got %b expected 0000", gnt); end
      cyc();
      for (int i = 0; i < 2 * BL; i++) begin
         n_chk++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL lone_gnt[%0d]: got %b expected 0100", i, gnt); end
         n_chk++; if (wr_en !== 1'b1 || ack !== 4'b0100) begin n_fail++; $display("FAIL lone_ack[%0d]: got en=%b ack=%b expected en=1 ack=0100", i, wr_en, ack); end
         n_chk++; if (wr_data !== 8'hA5) begin n_fail++; $display("FAIL lone_data[%0d]: got %h expected a5", i, wr_data); end
         cyc();
      end
      req = '0;
      cyc();
      n_chk++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL lone_release: got gnt=%b busy=%b expected 0000/0", gnt, busy); end
   endtask

   task automatic test_fairness();
      logic [N-1:0] exp;
      do_reset();
      req = 4'b1001;
      cyc();
      for (int i = 0; i < 3 * BL; i++) begin
         exp = ((i / BL) % 2 == 0) ? 4'b0001 : 4'b1000;
         n_chk++; if (ack !== exp || gnt !== exp || wr_en !== 1'b1) begin n_fail++; $display("FAIL fair[%0d]: got gnt=%b ack=%b en=%b expected %b", i, gnt, ack, wr_en, exp); end
         cyc();
      end
      req = '0;
      cyc(); cyc();
   endtask

   task automatic test_full_stall();
      do_reset();
      req = 4'b0010;
      cyc();
      for (int i = 0; i < 2; i++) begin
         n_chk++; if (wr_en !== 1'b1 || ack !== 4'b0010) begin n_fail++; $display("FAIL stall_pre[%0d]: got en=%b ack=%b expected 1/0010", i, wr_en, ack); end
         cyc();
      end
      full = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         n_chk++; if (wr_en !== 1'b0 || ack !== 4'b0000 || gnt !== 4'b0010) begin n_fail++; $display("FAIL stall_hold[%0d]: got en=%b ack=%b gnt=%b expected 0/0000/0010", i, wr_en, ack, gnt); end
         cyc();
      end
      full = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         if (i == 1) req = 4'b0011;
         #1;
         n_chk++; if (wr_en !== 1'b1 || ack !== 4'b0010) begin n_fail++; $display("FAIL stall_post[%0d]: got en=%b ack=%b expected 1/0010", i, wr_en, ack); end
         cyc();
      end
      n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL stall_release: got gnt=%b expected 0001", gnt); end
`ifdef FIFO_WR_ARB_STALL_CNT_EN
      n_chk++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL stall_cnt: got %0d expected 5", stall_cnt); end
`endif
      req = '0;
      cyc(); cyc();
   endtask

   task automatic test_withdraw();
      do_reset();
      req = 4'b0101;
      cyc();
      n_chk++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL wd_first: got ack=%b expected 0001", ack); end
      cyc();
      req = 4'b0100;
      #1;
      n_chk++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL wd_no_write: got en=%b expected 0", wr_en); end
      cyc();
      n_chk++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL wd_regrant: got gnt=%b expected 0100", gnt); end
      req = 4'b0101;
      #1;
      for (int i = 0; i < BL; i++) begin
         n_chk++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL wd_burst[%0d]: got ack=%b expected 0100", i, ack); end
         cyc();
      end
      n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wd_after: got gnt=%b expected 0001", gnt); end
      req = '0;
      cyc(); cyc();
   endtask

   task automatic test_mid_reset();
      do_reset();
      req = 4'b1000;
      cyc();
      cyc(); cyc();
      rst = 1'b1;
      cyc();
      n_chk++; if (gnt !== 4'b0000 || busy !== 1'b0 || wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst: got gnt=%b busy=%b en=%b expected 0000/0/0", gnt, busy, wr_en); end
`ifdef FIFO_WR_ARB_STALL_CNT_EN
      n_chk++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL mid_rst_stall: got %h expected 0000", stall_cnt); end
`endif
      rst = 1'b0;
      cyc();
      n_chk++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL mid_regrant: got gnt=%b expected 1000", gnt); end
      for (int i = 0; i < BL; i++) begin
         n_chk++; if (ack !== 4'b1000) begin n_fail++; $display("FAIL mid_burst[%0d]: got ack=%b expected 1000", i, ack); end
         cyc();
      end
      req = '0;
      cyc(); cyc();
   endtask

   task automatic test_random();
      logic [N-1:0]  e_gnt, e_ack;
      logic          e_en;
      logic [DW-1:0] e_data;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rst  = ($urandom_range(63) == 0);
         for (int k = 0; k < N; k++) if ($urandom_range(7) == 0) req[k] = ~req[k];
         full = ($urandom_range(3) == 0);
         data = $urandom;
         #1;
         e_gnt  = (m_owner < 0) ? '0 : (4'b0001 << m_owner);
         e_en   = m_accept();
         e_ack  = e_en ? (4'b0001 << m_owner) : '0;
         e_data = e_en ? data[m_owner*DW +: DW] : '0;
         n_chk++; if (gnt !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt@%0d: got %b expected %b", c, gnt, e_gnt); end
         n_chk++; if (wr_en !== e_en || ack !== e_ack) begin n_fail++; $display("FAIL rnd_ack@%0d: got en=%b ack=%b expected en=%b ack=%b", c, wr_en, ack, e_en, e_ack); end
         n_chk++; if (wr_data !== e_data) begin n_fail++; $display("FAIL rnd_data@%0d: got %h expected %h", c, wr_data, e_data); end
         n_chk++; if (busy !== (m_owner >= 0)) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b expected %b", c, busy, (m_owner >= 0)); end
`ifdef FIFO_WR_ARB_STALL_CNT_EN
         n_chk++; if (stall_cnt !== 16'(m_stall)) begin n_fail++; $display("FAIL rnd_stall@%0d: got %0d expected %0d", c, stall_cnt, m_stall); end
`endif
         cyc();
      end
      rst = 1'b0; req = '0;
      cyc(); cyc();
   endtask

   initial begin
      rst = 1'b1; req = '0; data = '0; full = 1'b0;
      #1;
      test_reset();
      test_lone();
      test_fairness();
      test_full_stall();
      test_withdraw();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing the single write port of the team's async FIFO write side among NUM_REQ requesters, all in the write clock domain.
- Grants one owner at a time for bursts of up to BURST_LEN words.
- Drives the FIFO write enable and data, and never writes while the FIFO full flag is high.

Parameters:
- NUM_REQ, 4, number of requesters; must be at least 2.
- DATA_WIDTH, 8, word width.
- BURST_LEN, 4, maximum accepted writes per grant; must be at least 1.

Ports:
- i_wr_clk  in  1  write-domain clock.
- i_rst  in  1  reset, synchronous to i_wr_clk, active-high.
- i_req  in  NUM_REQ  per-requester write request, level.
- i_data  in  NUM_REQ*DATA_WIDTH  flattened write data; requester k uses slice [k*DATA_WIDTH +: DATA_WIDTH].
- i_full_flag  in  1  FIFO full flag from the write-pointer/full logic.
- o_gnt  out  NUM_REQ  registered one-hot grant, or all zero.
- o_ack  out  NUM_REQ  one-hot; bit k is high in the cycle requester k's word is written.
- o_wr_en  out  1  FIFO write enable.
- o_wr_data  out  DATA_WIDTH  FIFO write data.
- o_busy  out  1  a grant is held.

Behaviour:
- One clock domain, single i_wr_clk; i_rst is synchronous and active-high.
- Reset (any cycle, including mid-burst) clears:
  - state to IDLE, o_gnt to 0, owner index to 0;
  - round-robin pointer to 0, so requester 0 has highest priority first;
  - burst counter to 0.
- Consequently o_wr_en, o_ack, o_wr_data and o_busy are all 0 after reset.
- Accept condition: accept = (state==GRANT) & i_req[owner] & ~i_full_flag. This is combinational, same cycle.
  - o_wr_en = accept.
  - o_ack = accept ? onehot(owner) : 0.
  - o_wr_data = accept ? i_data slice[owner] : 0.
- FSM states:
  - IDLE → GRANT when |i_req. The owner is picked round-robin starting at the pointer, and o_gnt is registered, so the first write happens 1 cycle after the request is seen.
  - GRANT → release when either:
    - (accept & burst_cnt==BURST_LEN-1), i.e. the burst is complete; or
    - ~i_req[owner], i.e. the owner withdrew.
  - GRANT with i_full_flag high and i_req[owner] high holds. Grant, owner and burst_cnt are all frozen, with no timeout.
- Release re-arbitration happens in the same cycle:
  - Pointer becomes owner+1 mod NUM_REQ.
  - Next owner is chosen from the current i_req, with the releasing owner masked if it withdrew.
  - If a requester is found: stay in GRANT with the new owner and burst_cnt=0, with no idle gap.
  - Otherwise: go to IDLE with o_gnt=0.
- A lone requester holding i_req is re-granted itself at burst end, so writes stay back-to-back.
- burst_cnt is $clog2(BURST_LEN+1) bits, increments only on accept, and clears on each new grant. The owner index is $clog2(NUM_REQ) bits and wraps modulo NUM_REQ.
- Requesters must hold i_req and data stable until o_ack is seen. Deasserting i_req without an ack is legal and causes release.

Optional Feature:
- Macro: FIFO_WR_ARB_STALL_CNT_EN.
- Defined:
  - Adds output o_stall_cnt, 16 bits, reset to 0.
  - Increments each cycle with (state==GRANT) & i_req[owner] & i_full_flag.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fifo_wr_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - the stall counter width constant (16);
  - a function for the width of the index and burst counter.
- Sub-module rr_pick: purely combinational. Inputs are the request vector and the pointer. Outputs are found and index.

Test Plan:
(NUM_REQ=4, DATA_WIDTH=8, BURST_LEN=4.)
- Reset: i_rst high for 2 cycles while i_req=4'b1111 → o_gnt=0, o_wr_en=0, o_wr_data=0, o_busy=0. The first grant after release of reset is 4'b0001.
- Lone requester: i_req=4'b0100 held, data 8'hA5, full=0 → o_gnt=4'b0100 one cycle later. o_wr_en is then continuous for 8 cycles, o_ack=4'b0100 every cycle, and there is no gap at the burst boundary.
- Fairness: i_req=4'b1001 held → 4 writes for req0, 4 for req3, then 4 for req0. The o_gnt change coincides with the 4th ack, with no idle cycle.
- Full stall: req1 gets a burst; after 2 accepts, i_full_flag goes high for 5 cycles → o_wr_en=0 and o_gnt=4'b0010 held for those 5 cycles, then exactly 2 more writes, then release.
- Withdraw: req0 owns; after 1 write i_req[0] drops while req2 is pending → o_gnt=4'b0100 next cycle, and req2's burst_cnt starts at 0.
- Mid-burst reset: i_rst pulsed after 2 writes of a req3 burst → next cycle o_gnt=0 and the pointer resets. With i_req=4'b1000 still held, regrant to req3 happens 1 cycle after i_rst drops, followed by a full 4-write burst. With FIFO_WR_ARB_STALL_CNT_EN defined, o_stall_cnt=0 after reset.
